// File: rtl/scan_pkg.sv
// scan_pkg: shared state encodings, sizes and helpers for the digit scanner.
// Imported by digit_scan_ctrl and scan_next_sel.
package scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    function automatic logic [SEL_W-1:0] lowest_set(
        input logic [NUM_DIGITS-1:0] mask
    );
        lowest_set = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (mask[i]) lowest_set = SEL_W'(i);
        end
    endfunction

endpackage

// File: rtl/scan_next_sel.sv
// scan_next_sel: next enabled digit after sel, searching cyclically.
// Falls back to sel+1 when the mask is empty.
module scan_next_sel
    import scan_pkg::*;
(
    input  logic [SEL_W-1:0]      sel,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [SEL_W-1:0]      next_sel
);

    logic [SEL_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        next_sel = sel + SEL_W'(1);
        idx      = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            idx = sel + SEL_W'(k + 1);
            if (digit_mask[idx]) next_sel = idx;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: rotating select/enable sequencer for a 2:4 decoder.
// Define SCAN_BLANK_EN to insert BLANK_CYCLES of blanking after each slot.
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] digit_mask,
    output logic [1:0] sel,
    output logic       en,
    output logic       tick,
    output logic       busy
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("PRESCALE must be at least 2");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $error("BLANK_CYCLES must be at least 1");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [SEL_W-1:0] nsel;

`ifdef SCAN_BLANK_EN
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    logic [BW-1:0] bcnt;
`endif

    scan_next_sel u_next (
        .sel        (sel),
        .digit_mask (digit_mask),
        .next_sel   (nsel)
    );

    // run=0 outranks the slot end, so a stop never advances sel.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            state <= ST_IDLE;
            sel   <= '0;
            cnt   <= '0;
`ifdef SCAN_BLANK_EN
            bcnt  <= '0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state <= ST_SCAN;
                    sel   <= lowest_set(digit_mask);
                    cnt   <= '0;
                end
                ST_SCAN: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        sel <= nsel;
`ifdef SCAN_BLANK_EN
                        state <= ST_BLANK;
                        bcnt  <= '0;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef SCAN_BLANK_EN
                ST_BLANK: begin
                    if (bcnt == BLANK_LAST) begin
                        state <= ST_SCAN;
                        cnt   <= '0;
                    end else begin
                        bcnt <= bcnt + BW'(1);
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign en   = (state == ST_SCAN) && digit_mask[sel];
    assign tick = (state == ST_SCAN) && (cnt == CNT_LAST);
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: vector table, corner sequences and random run
// against a slot-timeline reference model.
module tb_digit_scan_ctrl;

    localparam int P = 4;
    localparam int B = 2;
`ifdef SCAN_BLANK_EN
    localparam int PERIOD = P + B;
`else
    localparam int PERIOD = P;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [3:0] digit_mask = 4'b1111;
    logic [1:0] sel;
    logic       en;
    logic       tick;
    logic       busy;

    logic [1:0] ns_sel = '0;
    logic [3:0] ns_mask = '0;
    logic [1:0] ns_out;

    int checks = 0;
    int errors = 0;

    bit m_active = 0;
    int m_digit  = 0;
    int m_age    = 0;

    always #5 clk = ~clk;

    digit_scan_ctrl #(
        .PRESCALE     (P),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .digit_mask (digit_mask),
        .sel        (sel),
        .en         (en),
        .tick       (tick),
        .busy       (busy)
    );

    scan_next_sel u_ns (
        .sel        (ns_sel),
        .digit_mask (ns_mask),
        .next_sel   (ns_out)
    );

    typedef struct {
        logic       rst;
        logic       run;
        logic [3:0] mask;
        logic [1:0] sel;
        logic       en;
        logic       tick;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic ru, logic [3:0] m,
                                logic [1:0] s, logic e, logic t, logic b);
        vec_t v;
        v.rst = r; v.run = ru; v.mask = m;
        v.sel = s; v.en = e; v.tick = t; v.busy = b;
        return v;
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Enabled digits in ascending order; next is the first above cur.
    function automatic int next_digit(int cur, logic [3:0] m);
        int q[$];
        for (int d = 0; d < 4; d++) if (m[d]) q.push_back(d);
        if (q.size() == 0) return (cur + 1) % 4;
        foreach (q[i]) if (q[i] > cur) return q[i];
        return q[0];
    endfunction

    function automatic int first_digit(logic [3:0] m);
        for (int d = 0; d < 4; d++) if (m[d]) return d;
        return 0;
    endfunction

    task automatic model_update(logic r, logic ru, logic [3:0] m);
        if (r || !ru) begin
            m_active = 0; m_digit = 0; m_age = 0;
        end else if (!m_active) begin
            m_active = 1; m_digit = first_digit(m); m_age = 0;
        end else begin
            if (m_age % PERIOD == P - 1) m_digit = next_digit(m_digit, m);
            m_age++;
        end
    endtask

    task automatic check_model();
        int ph;
        ph = m_age % PERIOD;
        chk("m_busy", {3'b0, busy}, {3'b0, m_active});
        chk("m_sel", {2'b0, sel}, 4'(m_digit));
        chk("m_tick", {3'b0, tick}, {3'b0, m_active && ph == P - 1});
        chk("m_en", {3'b0, en},
            {3'b0, m_active && ph < P && digit_mask[m_digit]});
    endtask

    task automatic step(logic r, logic ru, logic [3:0] m);
        rst = r; run = ru; digit_mask = m;
        @(posedge clk);
        model_update(r, ru, m);
        #1;
        check_model();
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        bit hit;

        for (int s = 0; s < 4; s++) begin
            for (int m = 0; m < 16; m++) begin
                ns_sel = 2'(s); ns_mask = 4'(m);
                #1;
                chk("next_sel", {2'b0, ns_out}, 4'(next_digit(s, 4'(m))));
            end
        end

        tbl.push_back(mk(1, 0, 4'hF, 0, 0, 0, 0));
`ifdef SCAN_BLANK_EN
        for (int k = 1; k <= 4; k++)
            tbl.push_back(mk(0, 1, 4'hF, 0, 1, k == 4, 1));
        tbl.push_back(mk(0, 1, 4'hF, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4'hF, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4'hF, 1, 1, 0, 1));
`else
        for (int k = 1; k <= 17; k++)
            tbl.push_back(mk(0, 1, 4'hF, 2'((k - 1) / 4 % 4), 1,
                             (k - 1) % 4 == 3, 1));
`endif
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].run, tbl[i].mask);
            chk("t_sel", {2'b0, sel}, {2'b0, tbl[i].sel});
            chk("t_en", {3'b0, en}, {3'b0, tbl[i].en});
            chk("t_tick", {3'b0, tick}, {3'b0, tbl[i].tick});
            chk("t_busy", {3'b0, busy}, {3'b0, tbl[i].busy});
        end

        // Skip digits: only 1 and 3 may ever be selected.
        step(1, 0, 4'b1010);
        step(0, 1, 4'b1010);
        chk("skip_first", {2'b0, sel}, 4'd1);
        for (int i = 0; i < 4 * PERIOD; i++) begin
            step(0, 1, 4'b1010);
            chk("skip_odd", {3'b0, sel[0]}, 4'd1);
        end

        // Empty mask: busy, never enabled, sel still steps.
        step(1, 0, 4'b0000);
        step(0, 1, 4'b0000);
        chk("empty_busy", {3'b0, busy}, 4'd1);
        chk("empty_en", {3'b0, en}, 4'd0);
        for (int i = 0; i < PERIOD; i++) step(0, 1, 4'b0000);
        chk("empty_sel", {2'b0, sel}, 4'd1);

        // Stop during the tick at sel=2, then restart.
        step(1, 0, 4'b1111);
        n = 0; hit = 0;
        while (!hit && n < 50) begin
            step(0, 1, 4'b1111);
            hit = (sel == 2'd2) && tick;
            n++;
        end
        chk("stop_found", {3'b0, hit}, 4'd1);
        step(0, 0, 4'b1111);
        chk("stop_busy", {3'b0, busy}, 4'd0);
        chk("stop_en", {3'b0, en}, 4'd0);
        chk("stop_sel", {2'b0, sel}, 4'd0);
        step(0, 1, 4'b1111);
        chk("restart_sel", {2'b0, sel}, 4'd0);
        chk("restart_en", {3'b0, en}, 4'd1);
        for (int i = 1; i < P; i++) begin
            chk("restart_notick", {3'b0, tick}, 4'd0);
            step(0, 1, 4'b1111);
        end
        chk("restart_tick", {3'b0, tick}, 4'd1);

        // Mask change mid-slot: en drops at once, slot length unchanged.
        step(1, 0, 4'b1111);
        step(0, 1, 4'b1111);
        step(0, 1, 4'b1111);
        digit_mask = 4'b1110;
        #1;
        chk("mask_en", {3'b0, en}, 4'd0);
        step(0, 1, 4'b1110);
        step(0, 1, 4'b1110);
        chk("mask_tick", {3'b0, tick}, 4'd1);

        // Reset mid-slot at sel=1, cnt=2.
        step(1, 0, 4'b1111);
        n = 0;
        while (!(m_active && m_digit == 1 && m_age % PERIOD == 2)
               && n < 50) begin
            step(0, 1, 4'b1111);
            n++;
        end
        chk("rst_found", {2'b0, sel}, 4'd1);
        step(1, 1, 4'b1111);
        chk("rst_sel", {2'b0, sel}, 4'd0);
        chk("rst_en", {3'b0, en}, 4'd0);
        chk("rst_tick", {3'b0, tick}, 4'd0);
        chk("rst_busy", {3'b0, busy}, 4'd0);

        // Random traffic against the model.
        begin
            logic [3:0] m;
            logic r, ru;
            m = 4'b1111; ru = 1;
            for (int i = 0; i < 3000; i++) begin
                r = ($urandom_range(0, 60) == 0);
                if ($urandom_range(0, 25) == 0) ru = ~ru;
                else if (!ru && $urandom_range(0, 3) == 0) ru = 1;
                if ($urandom_range(0, 12) == 0) m = 4'($urandom);
                step(r, ru, m);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
